// File: rtl/tcb_vip_pkg.sv
// rtl/tcb_vip_pkg.sv - shared TCB VIP types and address-check helper
package tcb_vip_pkg;

    localparam int unsigned TCB_DAT = 32;

    typedef struct packed {
        logic [TCB_DAT-1:0] rdt;
        logic               err;
        logic               vld;
    } tcb_rsp_t;

    // Out-of-range or misaligned byte address; siz and ben are powers of 2.
    function automatic logic tcb_adr_err(
        input logic [63:0] adr,
        input int unsigned siz,
        input int unsigned ben
    );
        logic [63:0] msk;
        msk = 64'(ben) - 64'd1;
        return (adr >= 64'(siz)) || ((adr & msk) != 64'd0);
    endfunction

endpackage

// File: rtl/tcb_vip_dly.sv
// rtl/tcb_vip_dly.sv - fixed-latency response pipeline
module tcb_vip_dly
    import tcb_vip_pkg::*;
#(
    parameter int unsigned DLY   = 1,
    parameter type         rsp_t = tcb_rsp_t
) (
    input  logic clk,
    input  logic rst,
    input  logic hsk_i,
    input  rsp_t rsp_i,
    output rsp_t rsp_o
);

    rsp_t stg_q [DLY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DLY); i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            stg_q[0] <= hsk_i ? rsp_i : '0;
            for (int i = 1; i < int'(DLY); i++) begin
                stg_q[i] <= stg_q[i-1];
            end
        end
    end

    assign rsp_o = stg_q[DLY-1];

endmodule

// File: rtl/tcb_vip_memory.sv
// rtl/tcb_vip_memory.sv - TCB subordinate memory model with fixed response delay
module tcb_vip_memory
    import tcb_vip_pkg::*;
#(
    parameter int unsigned ADR   = 32,
    parameter int unsigned DAT   = 32,
    parameter int unsigned BEN   = DAT/8,
    parameter int unsigned SIZ   = 4096,
    parameter int unsigned DLY   = 1,
    parameter int unsigned STALL = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tcb_vld,
    output logic           tcb_rdy,
    input  logic           tcb_wen,
    input  logic [ADR-1:0] tcb_adr,
    input  logic [BEN-1:0] tcb_ben,
    input  logic [DAT-1:0] tcb_wdt,
    output logic [DAT-1:0] tcb_rdt,
    output logic           tcb_err
);

    localparam int unsigned AW = $clog2(SIZ);
    localparam int unsigned BW = $clog2(BEN);
    localparam int unsigned IW = AW - BW;
    localparam int unsigned CW = (STALL > 0) ? $clog2(STALL + 1) : 1;

    typedef struct packed {
        logic [DAT-1:0] rdt;
        logic           err;
        logic           vld;
    } rsp_t;

    logic [DAT-1:0] mem [SIZ/BEN];
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           hsk;
    logic           adr_err;
    logic [IW-1:0]  idx;
    rsp_t           rsp_d, rsp_q;

    assign tcb_rdy = (cnt_q == '0);
    assign hsk     = tcb_vld & tcb_rdy;
    assign adr_err = tcb_adr_err(64'(tcb_adr), SIZ, BEN);
    assign idx     = tcb_adr[AW-1:BW];

    // With STALL=0 the counter is always loaded with zero, so rdy never drops.
    always_comb begin
        cnt_d = cnt_q;
        if (hsk) begin
            cnt_d = CW'(STALL);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (hsk && tcb_wen && !adr_err) begin
            for (int i = 0; i < int'(BEN); i++) begin
                if (tcb_ben[i]) begin
                    mem[idx][8*i +: 8] <= tcb_wdt[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rsp_d     = '0;
        rsp_d.vld = 1'b1;
        rsp_d.err = adr_err;
        rsp_d.rdt = (!tcb_wen && !adr_err) ? mem[idx] : '0;
    end

    tcb_vip_dly #(
        .DLY   (DLY),
        .rsp_t (rsp_t)
    ) u_dly (
        .clk   (clk),
        .rst   (rst),
        .hsk_i (hsk),
        .rsp_i (rsp_d),
        .rsp_o (rsp_q)
    );

    assign tcb_rdt = rsp_q.vld ? rsp_q.rdt : '0;
    assign tcb_err = rsp_q.vld & rsp_q.err;

endmodule

// File: tb/tb_tcb_vip_memory.sv
// tb/tb_tcb_vip_memory.sv - directed self-checking bench for tcb_vip_memory
module tb_tcb_vip_memory;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    // a: DLY=1 STALL=0, b: DLY=3 STALL=0, c: DLY=1 STALL=2
    logic        a_vld, a_rdy, a_wen, a_err;
    logic [31:0] a_adr, a_wdt, a_rdt;
    logic [3:0]  a_ben;
    logic        b_vld, b_rdy, b_wen, b_err;
    logic [31:0] b_adr, b_wdt, b_rdt;
    logic [3:0]  b_ben;
    logic        c_vld, c_rdy, c_wen, c_err;
    logic [31:0] c_adr, c_wdt, c_rdt;
    logic [3:0]  c_ben;

    tcb_vip_memory #(.DLY(1), .STALL(0)) u_a (
        .clk(clk), .rst(rst), .tcb_vld(a_vld), .tcb_rdy(a_rdy), .tcb_wen(a_wen),
        .tcb_adr(a_adr), .tcb_ben(a_ben), .tcb_wdt(a_wdt), .tcb_rdt(a_rdt), .tcb_err(a_err)
    );
    tcb_vip_memory #(.DLY(3), .STALL(0)) u_b (
        .clk(clk), .rst(rst), .tcb_vld(b_vld), .tcb_rdy(b_rdy), .tcb_wen(b_wen),
        .tcb_adr(b_adr), .tcb_ben(b_ben), .tcb_wdt(b_wdt), .tcb_rdt(b_rdt), .tcb_err(b_err)
    );
    tcb_vip_memory #(.DLY(1), .STALL(2)) u_c (
        .clk(clk), .rst(rst), .tcb_vld(c_vld), .tcb_rdy(c_rdy), .tcb_wen(c_wen),
        .tcb_adr(c_adr), .tcb_ben(c_ben), .tcb_wdt(c_wdt), .tcb_rdt(c_rdt), .tcb_err(c_err)
    );

    // Single transfer on u_a; entered and left just after a rising edge.
    task automatic a_xfer(input logic wen, input logic [31:0] adr, input logic [3:0] ben,
                          input logic [31:0] wdt, output logic [31:0] rdt, output logic err);
        a_vld = 1'b1; a_wen = wen; a_adr = adr; a_ben = ben; a_wdt = wdt;
        @(posedge clk); #1;
        a_vld = 1'b0;
        @(negedge clk);
        rdt = a_rdt; err = a_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        ntests++; if (a_rdy !== 1'b1) begin nfail++; $display("FAIL reset_rdy_a got=%b exp=1", a_rdy); end
        ntests++; if (c_rdy !== 1'b1) begin nfail++; $display("FAIL reset_rdy_c got=%b exp=1", c_rdy); end
        ntests++; if (a_rdt !== 32'h0) begin nfail++; $display("FAIL reset_rdt_a got=%h exp=0", a_rdt); end
        ntests++; if (b_err !== 1'b0) begin nfail++; $display("FAIL reset_err_b got=%b exp=0", b_err); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_full_write();
        logic [31:0] r; logic e;
        a_xfer(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, r, e);
        ntests++; if (r !== 32'h0 || e !== 1'b0) begin nfail++; $display("FAIL wr_rsp got=%h/%b exp=0/0", r, e); end
        a_xfer(1'b0, 32'h10, 4'hF, 32'h0, r, e);
        ntests++; if (r !== 32'hDEADBEEF) begin nfail++; $display("FAIL full_rd got=%h exp=deadbeef", r); end
        ntests++; if (e !== 1'b0) begin nfail++; $display("FAIL full_rd_err got=%b exp=0", e); end
    endtask

    task automatic test_partial_write();
        logic [31:0] r; logic e;
        a_xfer(1'b1, 32'h20, 4'hF, 32'hDEADBEEF, r, e);
        a_xfer(1'b1, 32'h20, 4'b0101, 32'h11223344, r, e);
        a_xfer(1'b0, 32'h20, 4'hF, 32'h0, r, e);
        ntests++; if (r !== 32'hDE22BE44) begin nfail++; $display("FAIL partial_rd got=%h exp=de22be44", r); end
        a_xfer(1'b1, 32'h20, 4'h0, 32'h0, r, e);
        a_xfer(1'b0, 32'h20, 4'hF, 32'h0, r, e);
        ntests++; if (r !== 32'hDE22BE44) begin nfail++; $display("FAIL ben0_noop got=%h exp=de22be44", r); end
    endtask

    task automatic test_back_to_back();
        a_vld = 1'b1; a_wen = 1'b1; a_adr = 32'h30; a_ben = 4'hF; a_wdt = 32'hCAFEF00D;
        @(posedge clk); #1;
        a_wen = 1'b0;
        @(posedge clk); #1;
        a_vld = 1'b0;
        @(negedge clk);
        ntests++; if (a_rdt !== 32'hCAFEF00D) begin nfail++; $display("FAIL wr_then_rd got=%h exp=cafef00d", a_rdt); end
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        logic [31:0] r; logic e;
        a_xfer(1'b1, 32'h0, 4'hF, 32'hA5A5A5A5, r, e);
        a_xfer(1'b0, 32'h1000, 4'hF, 32'h0, r, e);
        ntests++; if (e !== 1'b1 || r !== 32'h0) begin nfail++; $display("FAIL err_range got=%h/%b exp=0/1", r, e); end
        a_xfer(1'b0, 32'h2, 4'hF, 32'h0, r, e);
        ntests++; if (e !== 1'b1 || r !== 32'h0) begin nfail++; $display("FAIL err_align got=%h/%b exp=0/1", r, e); end
        a_xfer(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, r, e);
        ntests++; if (e !== 1'b1) begin nfail++; $display("FAIL err_wr_range got=%b exp=1", e); end
        a_xfer(1'b1, 32'h2, 4'hF, 32'h12345678, r, e);
        a_xfer(1'b0, 32'h0, 4'hF, 32'h0, r, e);
        ntests++; if (r !== 32'hA5A5A5A5 || e !== 1'b0) begin nfail++; $display("FAIL err_mem_kept got=%h/%b exp=a5a5a5a5/0", r, e); end
    endtask

    task automatic test_pipeline();
        b_vld = 1'b1; b_wen = 1'b1; b_ben = 4'hF;
        for (int i = 0; i < 4; i++) begin
            b_adr = 32'(i * 4); b_wdt = 32'(i + 1);
            @(posedge clk); #1;
        end
        b_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        b_wen = 1'b0; b_adr = 32'h0; b_vld = 1'b1;
        @(posedge clk); #1; b_adr = 32'h4;
        @(posedge clk); #1; b_adr = 32'h8;
        @(negedge clk);
        ntests++; if (b_rdt !== 32'h0) begin nfail++; $display("FAIL pipe_early got=%h exp=0", b_rdt); end
        @(posedge clk); #1; b_adr = 32'hC;
        @(negedge clk);
        ntests++; if (b_rdt !== 32'd1) begin nfail++; $display("FAIL pipe_rsp0 got=%h exp=1", b_rdt); end
        @(posedge clk); #1; b_vld = 1'b0;
        @(negedge clk);
        ntests++; if (b_rdt !== 32'd2) begin nfail++; $display("FAIL pipe_rsp1 got=%h exp=2", b_rdt); end
        @(negedge clk);
        ntests++; if (b_rdt !== 32'd3) begin nfail++; $display("FAIL pipe_rsp2 got=%h exp=3", b_rdt); end
        @(negedge clk);
        ntests++; if (b_rdt !== 32'd4) begin nfail++; $display("FAIL pipe_rsp3 got=%h exp=4", b_rdt); end
        @(negedge clk);
        ntests++; if (b_rdt !== 32'h0 || b_err !== 1'b0) begin nfail++; $display("FAIL pipe_idle got=%h/%b exp=0/0", b_rdt, b_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        logic [5:0] rdy_exp;
        logic [5:0] err_exp;
        rdy_exp = 6'b001001;
        err_exp = 6'b010010;
        c_vld = 1'b1; c_wen = 1'b1; c_adr = 32'h2; c_ben = 4'h0; c_wdt = 32'h0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ntests++; if (c_rdy !== rdy_exp[k]) begin nfail++; $display("FAIL stall_rdy[%0d] got=%b exp=%b", k, c_rdy, rdy_exp[k]); end
            ntests++; if (c_err !== err_exp[k]) begin nfail++; $display("FAIL stall_rsp[%0d] got=%b exp=%b", k, c_err, err_exp[k]); end
            @(posedge clk);
        end
        #1;
        c_vld = 1'b0;
    endtask

    task automatic test_reset_midflight();
        b_wen = 1'b0; b_adr = 32'h0; b_vld = 1'b1;
        @(posedge clk); #1; b_adr = 32'h4;
        @(posedge clk); #1; b_vld = 1'b0; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ntests++; if (b_rdt !== 32'h0 || b_err !== 1'b0) begin nfail++; $display("FAIL rst_flush[%0d] got=%h/%b exp=0/0", k, b_rdt, b_err); end
        end
        @(posedge clk); #1;
        b_vld = 1'b1; b_wen = 1'b1; b_adr = 32'h40; b_ben = 4'hF; b_wdt = 32'h55AA55AA;
        @(posedge clk); #1; b_wen = 1'b0;
        @(posedge clk); #1; b_vld = 1'b0;
        @(posedge clk); @(negedge clk);
        ntests++; if (b_rdt !== 32'h0 || b_err !== 1'b0) begin nfail++; $display("FAIL post_rst_wr got=%h/%b exp=0/0", b_rdt, b_err); end
        @(posedge clk); @(negedge clk);
        ntests++; if (b_rdt !== 32'h55AA55AA) begin nfail++; $display("FAIL post_rst_rd got=%h exp=55aa55aa", b_rdt); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        a_vld = 1'b0; a_wen = 1'b0; a_adr = '0; a_ben = '0; a_wdt = '0;
        b_vld = 1'b0; b_wen = 1'b0; b_adr = '0; b_ben = '0; b_wdt = '0;
        c_vld = 1'b0; c_wen = 1'b0; c_adr = '0; c_ben = '0; c_wdt = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_full_write();
        test_partial_write();
        test_back_to_back();
        test_errors();
        test_pipeline();
        test_stall();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
